// File: rtl/mem_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mem_status_tracker
// Purpose  : Terminating consumer of the S2MM write-engine status stream.
//            Every issued write command pushes its tag into an in-order FIFO.
//            Every returned status beat pops the head tag and is checked
//            against it. The block produces a one-cycle completion pulse per
//            beat and raises sticky error flags. After any error it blocks
//            further command issue until software pulses err_clear.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk          in   1      clock
//   aresetn       in   1      asynchronous active-low reset
//   s_axis_valid  in   1      status beat valid
//   s_axis_ready  out  1      status beat ready (constant 1, never stalls)
//   s_axis_data   in   WIDTH  [7]OKAY [6]SLVERR [5]DECERR [4]INTERR [3:0]TAG
//   cmd_valid     in   1      write command issued this cycle (with cmd_ready)
//   cmd_ready     out  1      issue permitted
//   cmd_tag       in   4      tag of the issued command
//   done_valid    out  1      one-cycle completion pulse
//   done_tag      out  4      tag carried by the completing beat
//   done_ok       out  1      beat was OKAY with no error bits and tag matched
//   outstanding   out  CNT_W  commands issued and not yet completed
//   idle          out  1      nothing outstanding and state IDLE
//   err_status    out  1      sticky: beat with OKAY=0 or an error bit set
//   err_tag       out  1      sticky: beat tag differed from FIFO head
//   err_spurious  out  1      sticky: beat with nothing outstanding
//   err_clear     in   1      clears sticky flags and leaves FAULT
// ============================================================================
module mem_status_tracker #(
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 16,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  input  logic [WIDTH-1:0] s_axis_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_tag,
  output logic             done_valid,
  output logic [3:0]       done_tag,
  output logic             done_ok,
  output logic [CNT_W-1:0] outstanding,
  output logic             idle,
  output logic             err_status,
  output logic             err_tag,
  output logic             err_spurious,
  input  logic             err_clear
);

  localparam int AW = $clog2(MAX_OUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [3:0]       tag_mem [MAX_OUT];
  logic [CNT_W-1:0] out_nx;

  logic       issue;
  logic       accept;
  logic       pop;
  logic       spurious;
  logic       bad_status;
  logic       bad_tag;
  logic       any_err;
  logic [3:0] beat_tag;
  logic [3:0] head_tag;

  // Status is never back-pressured so the engine can never stall on us.
  assign s_axis_ready = 1'b1;

  assign issue      = cmd_valid & cmd_ready;
  assign accept     = s_axis_valid & s_axis_ready;
  assign pop        = accept & (outstanding != '0);
  assign spurious   = accept & (outstanding == '0);
  assign beat_tag   = s_axis_data[3:0];
  assign head_tag   = tag_mem[rd_ptr[AW-1:0]];
  assign bad_status = ~s_axis_data[7] | (|s_axis_data[6:4]);
  assign bad_tag    = (beat_tag != head_tag);
  assign any_err    = spurious | (pop & (bad_status | bad_tag));

  // Next outstanding count: a simultaneous push and pop cancel out.
  always_comb begin
    out_nx = outstanding;
    case ({issue, pop})
      2'b10:   out_nx = outstanding + 1'b1;
      2'b01:   out_nx = outstanding - 1'b1;
      default: out_nx = outstanding;
    endcase
  end

  // err_clear wins over an error detected in the same cycle, so that error
  // neither sets a flag nor enters FAULT. Leaving FAULT lands in IDLE or
  // ACTIVE depending on whether anything is still outstanding.
  always_comb begin
    state_nx = state;
    if (any_err && !err_clear) begin
      state_nx = ST_FAULT;
    end else if (state == ST_FAULT && !err_clear) begin
      state_nx = ST_FAULT;
    end else if (out_nx != '0) begin
      state_nx = ST_ACTIVE;
    end else begin
      state_nx = ST_IDLE;
    end
  end

  // Tag storage carries no reset: validity is defined purely by the pointers.
  always_ff @(posedge aclk) begin
    if (issue) begin
      tag_mem[wr_ptr[AW-1:0]] <= cmd_tag;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      done_valid   <= 1'b0;
      done_tag     <= 4'd0;
      done_ok      <= 1'b0;
      err_status   <= 1'b0;
      err_tag      <= 1'b0;
      err_spurious <= 1'b0;
      cmd_ready    <= 1'b1;
      idle         <= 1'b1;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;

      // Pointers carry one extra bit and wrap naturally at 2*MAX_OUT.
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      done_valid <= pop;
      done_ok    <= pop & ~bad_status & ~bad_tag;
      if (pop) begin
        done_tag <= beat_tag;
      end

      if (err_clear) begin
        err_status   <= 1'b0;
        err_tag      <= 1'b0;
        err_spurious <= 1'b0;
      end else begin
        err_status   <= err_status   | (pop & bad_status);
        err_tag      <= err_tag      | (pop & bad_tag);
        err_spurious <= err_spurious | spurious;
      end

      // Registered from next-state values: a full FIFO keeps cmd_ready low
      // for the whole cycle in which a beat frees a slot (no bypass).
      cmd_ready <= (out_nx < CNT_W'(MAX_OUT)) & (state_nx != ST_FAULT);
      idle      <= (out_nx == '0) & (state_nx == ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_status_tracker
// Purpose  : Self-checking bench for mem_status_tracker. A table of one-cycle
//            stimulus rows with expected status outputs, plus hand-written
//            sequences for the full-FIFO and mid-burst reset cases. Completion
//            pulses are checked against a scoreboard queue filled by a small
//            reference model as beats are driven.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_status_tracker;

  localparam int MAX_OUT = 16;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic             clk;
  logic             aresetn;
  logic             s_axis_valid;
  logic             s_axis_ready;
  logic [7:0]       s_axis_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_tag;
  logic             done_valid;
  logic [3:0]       done_tag;
  logic             done_ok;
  logic [CNT_W-1:0] outstanding;
  logic             idle;
  logic             err_status;
  logic             err_tag;
  logic             err_spurious;
  logic             err_clear;

  mem_status_tracker #(.WIDTH(8), .MAX_OUT(MAX_OUT)) dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_tag      (cmd_tag),
    .done_valid   (done_valid),
    .done_tag     (done_tag),
    .done_ok      (done_ok),
    .outstanding  (outstanding),
    .idle         (idle),
    .err_status   (err_status),
    .err_tag      (err_tag),
    .err_spurious (err_spurious),
    .err_clear    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] tag;
    logic       ok;
  } exp_t;

  typedef struct {
    logic       cv;
    logic [3:0] ct;
    logic       bv;
    logic [7:0] bd;
    logic       clr;
    logic [4:0] e_out;
    logic       e_crdy;
    logic       e_idle;
    logic       e_es;
    logic       e_et;
    logic       e_esp;
  } vec_t;

  exp_t       exp_q[$];
  logic [3:0] m_q[$];
  logic       m_fault = 1'b0;
  vec_t       vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard consumer: each pulse must match the oldest expectation, in
  // the exact cycle after its beat was accepted.
  always @(negedge clk) begin
    exp_t e;
    if (done_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done latency cycle", cyc, e.cyc);
        chk("done_tag", {28'd0, done_tag}, {28'd0, e.tag});
        chk("done_ok", {31'd0, done_ok}, {31'd0, e.ok});
      end
    end
  end

  // Drive one cycle of stimulus (called just after a negedge), update the
  // reference model, then return at the next negedge with inputs released.
  task automatic apply(input logic cv, input logic [3:0] ct, input logic bv,
                       input logic [7:0] bd, input logic clr);
    logic       m_issue;
    logic       m_err;
    logic       ok;
    logic [3:0] head;
    exp_t       e;
    m_issue = cv && (m_q.size() < MAX_OUT) && !m_fault;
    m_err   = 1'b0;
    if (bv) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        head  = m_q.pop_front();
        ok    = bd[7] && (bd[6:4] == 3'b000) && (bd[3:0] == head);
        m_err = !ok;
        e.cyc = cyc + 1;
        e.tag = bd[3:0];
        e.ok  = ok;
        exp_q.push_back(e);
      end
    end
    if (m_issue) m_q.push_back(ct);
    if (clr) m_fault = 1'b0;
    else if (m_err) m_fault = 1'b1;

    cmd_valid    = cv;
    cmd_tag      = ct;
    s_axis_valid = bv;
    s_axis_data  = bd;
    err_clear    = clr;
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd_tag      = 4'd0;
    s_axis_valid = 1'b0;
    s_axis_data  = 8'd0;
    err_clear    = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int e_out, input logic e_crdy,
                           input logic e_idle, input logic e_es, input logic e_et,
                           input logic e_esp);
    chk({tag, " outstanding"},  32'(outstanding),   32'(e_out));
    chk({tag, " cmd_ready"},    32'(cmd_ready),     32'(e_crdy));
    chk({tag, " idle"},         32'(idle),          32'(e_idle));
    chk({tag, " err_status"},   32'(err_status),    32'(e_es));
    chk({tag, " err_tag"},      32'(err_tag),       32'(e_et));
    chk({tag, " err_spurious"}, 32'(err_spurious),  32'(e_esp));
    chk({tag, " s_axis_ready"}, 32'(s_axis_ready),  32'd1);
  endtask

  initial begin
    aresetn      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_tag      = 4'd0;
    s_axis_valid = 1'b0;
    s_axis_data  = 8'd0;
    err_clear    = 1'b0;

    //          cv    ct     bv    bd      clr   out    crdy  idle  es    et    esp
    // In-order completions, then issue and accept in the same cycle.
    vecs.push_back('{1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h3, 1'b0, 8'h00, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h80, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h81, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h82, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h83, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h9, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hA, 1'b1, 8'h89, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h8A, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // SLVERR response enters FAULT; err_clear recovers.
    vecs.push_back('{1'b1, 4'h5, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'hC5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // Tag mismatch.
    vecs.push_back('{1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h83, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // Spurious beat with nothing outstanding.
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h80, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // err_clear beats a same-cycle error; a following error sets flags again.
    vecs.push_back('{1'b1, 4'h4, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h24, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h80, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // Beats still accepted and counted in FAULT; issue blocked in FAULT.
    vecs.push_back('{1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h2, 1'b0, 8'h00, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 8'h82, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h7, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset state with no traffic.
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk_state("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset done_valid", 32'(done_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].cv, vecs[i].ct, vecs[i].bv, vecs[i].bd, vecs[i].clr);
      chk_state($sformatf("row%0d", i), int'(vecs[i].e_out), vecs[i].e_crdy,
                vecs[i].e_idle, vecs[i].e_es, vecs[i].e_et, vecs[i].e_esp);
    end

    // Fill to MAX_OUT: issue is refused while full even as a beat frees a slot.
    for (int i = 0; i < MAX_OUT; i++) apply(1'b1, 4'(i), 1'b0, 8'h00, 1'b0);
    chk_state("full", MAX_OUT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'hC, 1'b1, 8'h80, 1'b0);
    chk_state("full beat+cmd", MAX_OUT - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 4'hC, 1'b0, 8'h00, 1'b0);
    chk_state("refill", MAX_OUT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < MAX_OUT; i++) apply(1'b0, 4'h0, 1'b1, 8'h80 | 8'(i), 1'b0);
    apply(1'b0, 4'h0, 1'b1, 8'h8C, 1'b0);
    chk_state("drained", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-burst drops everything immediately, without a clock edge.
    apply(1'b1, 4'h3, 1'b0, 8'h00, 1'b0);
    apply(1'b1, 4'h4, 1'b0, 8'h00, 1'b0);
    apply(1'b1, 4'h5, 1'b0, 8'h00, 1'b0);
    chk("pre-reset outstanding", 32'(outstanding), 32'd3);
    @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    chk_state("async reset", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    m_q.delete();
    m_fault = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    // FIFO is empty, so the returning beat is spurious.
    apply(1'b0, 4'h0, 1'b1, 8'h83, 1'b0);
    chk_state("post-reset beat", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
    chk_state("final clear", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending done pulses", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
